// File: rtl/bp_write_control_mg.sv
// bp_write_control_mg
// Streams a rectangular region of the BP buffer banks (line_num MAC groups of
// line_width words each) into a show-ahead FIFO feeding the DDR write engine.
// A read is issued only when the FIFO has room for it and for all reads still
// in the bank read pipeline. Because of this credit check the FIFO cannot
// overflow, whatever the value of READ_LAT.
module bp_write_control_mg #(
    parameter int X_MAC        = 4,
    parameter int X_MESH       = 16,
    parameter int ADDR_LEN     = 16,
    parameter int DATA_LEN     = 32,
    parameter int DDR_ADDR_LEN = 32,
    parameter int SINGLE_LEN   = 24,
    parameter int READ_LAT     = 1,
    parameter int FIFO_DEPTH   = 16,
    parameter int BUFFER_NUM   = X_MAC * X_MESH
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic                           conf,
    input  logic [DDR_ADDR_LEN-1:0]        ddr_st_addr,
    input  logic [SINGLE_LEN-1:0]          data_ddr_byte,
    input  logic [ADDR_LEN-1:0]            bp_st_addr,
    input  logic [$clog2(X_MAC)-1:0]       bp_st_mac,
    input  logic [SINGLE_LEN-1:0]          line_num,
    input  logic [SINGLE_LEN-1:0]          line_width,
    input  logic [ADDR_LEN-1:0]            addr_stride,
    input  logic                           axi_ug_idle,
    output logic [DDR_ADDR_LEN-1:0]        ddr_st_addr_out,
    output logic [SINGLE_LEN-1:0]          ddr_len,
    output logic                           ddr_conf,
    output logic                           ddr_write_empty,
    input  logic                           ddr_write_req,
    output logic [DATA_LEN*X_MESH-1:0]     ddr_write_data_out,
    output logic [ADDR_LEN*BUFFER_NUM-1:0] bp_addr_out,
    input  logic [DATA_LEN*BUFFER_NUM-1:0] bp_data_in,
    output logic                           idle,
    output logic [SINGLE_LEN-1:0]          beat_count
);

    localparam int MAC_W   = $clog2(X_MAC);
    localparam int BEAT_W  = DATA_LEN * X_MESH;
    localparam int FIFO_AW = $clog2(FIFO_DEPTH);
    localparam int CNT_W   = $clog2(FIFO_DEPTH + 1);
    localparam int INF_W   = $clog2(READ_LAT + 1);
    localparam int SUM_W   = $clog2(FIFO_DEPTH + READ_LAT + 1) + 1;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_RUN,
        ST_DRAIN
    } state_t;

    state_t state;
    state_t state_nxt;

    // job configuration captured when a job is accepted
    logic [ADDR_LEN-1:0]   cfg_bp_st_addr;
    logic [ADDR_LEN-1:0]   cfg_stride;
    logic [SINGLE_LEN-1:0] cfg_line_num;
    logic [SINGLE_LEN-1:0] cfg_line_width;

    // sweep position
    logic [ADDR_LEN-1:0]   addr;
    logic [SINGLE_LEN-1:0] col;
    logic [SINGLE_LEN-1:0] grp;
    logic [MAC_W-1:0]      mac_sel;

    logic accept;
    logic issue;
    logic credit;
    logic last_col;
    logic last_grp;

    // bank read pipeline: valid and group tag travel together
    logic                  vld_p [READ_LAT];
    logic [MAC_W-1:0]      tag_p [READ_LAT];
    logic [INF_W-1:0]      inflight;
    logic [BEAT_W-1:0]     push_beat;
    logic                  push;
    logic                  pop;

    // FIFO storage
    logic [BEAT_W-1:0]     fifo_mem [FIFO_DEPTH];
    logic [FIFO_AW-1:0]    wr_ptr;
    logic [FIFO_AW-1:0]    rd_ptr;
    logic [CNT_W-1:0]      fifo_count;
    logic                  fifo_full;

    // Pick the word of the selected MAC group for mesh lane m.
    function automatic logic [DATA_LEN-1:0] lane_word(
        input logic [DATA_LEN*BUFFER_NUM-1:0] bus,
        input logic [MAC_W-1:0]               mac,
        input int                             m
    );
        return bus[(int'(mac) + m * X_MAC) * DATA_LEN +: DATA_LEN];
    endfunction

    assign last_col  = (col == cfg_line_width - SINGLE_LEN'(1));
    assign last_grp  = (grp == cfg_line_num - SINGLE_LEN'(1));
    assign fifo_full = (fifo_count == CNT_W'(FIFO_DEPTH));
    assign credit    = (SUM_W'(fifo_count) + SUM_W'(inflight)) < SUM_W'(FIFO_DEPTH);
    assign push      = vld_p[READ_LAT-1];
    assign pop       = ddr_write_req && (fifo_count != '0);

    assign bp_addr_out        = {BUFFER_NUM{addr}};
    assign ddr_write_empty    = (fifo_count == '0);
    assign ddr_write_data_out = fifo_mem[rd_ptr];
    assign idle               = (state == ST_IDLE) && axi_ug_idle;

    // FSM state register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // FSM next state, job acceptance and read issue decision
    always_comb begin
        state_nxt = state;
        accept    = 1'b0;
        issue     = 1'b0;
        case (state)
            ST_IDLE: begin
                if (conf) begin
                    accept = 1'b1;
                    if ((line_num == '0) || (line_width == '0)) begin
                        state_nxt = ST_DRAIN;
                    end else begin
                        state_nxt = ST_RUN;
                    end
                end
            end
            ST_RUN: begin
                if (credit) begin
                    issue = 1'b1;
                    if (last_col && last_grp) begin
                        state_nxt = ST_DRAIN;
                    end
                end
            end
            ST_DRAIN: begin
                if (inflight == '0) begin
                    state_nxt = ST_IDLE;
                end
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    // capture the job configuration on acceptance
    always_ff @(posedge clk) begin
        if (accept) begin
            cfg_bp_st_addr <= bp_st_addr;
            cfg_stride     <= addr_stride;
            cfg_line_num   <= line_num;
            cfg_line_width <= line_width;
        end
    end

    // sweep counters: column-minor, group-major; hold while stalled
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            addr    <= '0;
            col     <= '0;
            grp     <= '0;
            mac_sel <= '0;
        end else if (accept) begin
            addr    <= bp_st_addr;
            col     <= '0;
            grp     <= '0;
            mac_sel <= bp_st_mac;
        end else if (issue) begin
            if (last_col) begin
                addr    <= cfg_bp_st_addr;
                col     <= '0;
                grp     <= grp + SINGLE_LEN'(1);
                mac_sel <= mac_sel + MAC_W'(1);
            end else begin
                addr    <= addr + cfg_stride;
                col     <= col + SINGLE_LEN'(1);
            end
        end
    end

    // DDR job handshake: one-cycle pulse with base and length updated alongside
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ddr_conf        <= 1'b0;
            ddr_st_addr_out <= '0;
            ddr_len         <= '0;
        end else begin
            ddr_conf <= accept;
            if (accept) begin
                ddr_st_addr_out <= ddr_st_addr;
                ddr_len         <= data_ddr_byte;
            end
        end
    end

    // ---- stage p0 .. p(READ_LAT-1): bank read in flight ----
    // read pipeline valids, one per cycle of bank latency
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < READ_LAT; i++) vld_p[i] <= 1'b0;
        end else begin
            vld_p[0] <= issue;
            for (int i = 1; i < READ_LAT; i++) vld_p[i] <= vld_p[i-1];
        end
    end

    // group tags follow their valids through the read pipeline
    always_ff @(posedge clk) begin
        tag_p[0] <= mac_sel;
        for (int i = 1; i < READ_LAT; i++) tag_p[i] <= tag_p[i-1];
    end

    // count of reads still in flight, used by the credit check
    always_comb begin
        inflight = '0;
        for (int i = 0; i < READ_LAT; i++) inflight = inflight + INF_W'(vld_p[i]);
    end

    // ---- last stage: assemble the beat from the tagged group's lanes ----
    // lane m comes from bank (tag + m*X_MAC); lane 0 in the LSBs
    always_comb begin
        push_beat = '0;
        for (int m = 0; m < X_MESH; m++) begin
            push_beat[m*DATA_LEN +: DATA_LEN] = lane_word(bp_data_in, tag_p[READ_LAT-1], m);
        end
    end

    // FIFO storage write
    always_ff @(posedge clk) begin
        if (push) begin
            fifo_mem[wr_ptr] <= push_beat;
        end
    end

    // FIFO pointers and occupancy; a pop on empty is ignored
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            fifo_count <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + FIFO_AW'(1);
            if (pop)  rd_ptr <= rd_ptr + FIFO_AW'(1);
            case ({push, pop})
                2'b10:   fifo_count <= fifo_count + CNT_W'(1);
                2'b01:   fifo_count <= fifo_count - CNT_W'(1);
                default: fifo_count <= fifo_count;
            endcase
        end
    end

    // beats pushed in the current job
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            beat_count <= '0;
        end else if (accept) begin
            beat_count <= '0;
        end else if (push) begin
            beat_count <= beat_count + SINGLE_LEN'(1);
        end
    end

    // the credit check must never let a push land on a full FIFO without a pop
    assert property (@(posedge clk) disable iff (rst) !(push && fifo_full && !pop));

endmodule

// File: tb/tb_bp_write_control_mg.sv
// Bench for bp_write_control_mg: drives a READ_LAT=1 and a READ_LAT=3 instance
// with identical stimulus and compares each popped beat stream with a job-level
// model (group-major, column-minor enumeration of bank words).
module tb_bp_write_control_mg;

    localparam int X_MAC        = 4;
    localparam int X_MESH       = 16;
    localparam int ADDR_LEN     = 16;
    localparam int DATA_LEN     = 32;
    localparam int DDR_ADDR_LEN = 32;
    localparam int SINGLE_LEN   = 24;
    localparam int FIFO_DEPTH   = 16;
    localparam int BN           = X_MAC * X_MESH;
    localparam int MAC_W        = $clog2(X_MAC);
    localparam int BW           = DATA_LEN * X_MESH;
    localparam int ABUS         = ADDR_LEN * BN;
    localparam int DBUS         = DATA_LEN * BN;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic                    rst;
    logic                    conf;
    logic [DDR_ADDR_LEN-1:0] ddr_st_addr;
    logic [SINGLE_LEN-1:0]   data_ddr_byte;
    logic [ADDR_LEN-1:0]     bp_st_addr;
    logic [MAC_W-1:0]        bp_st_mac;
    logic [SINGLE_LEN-1:0]   line_num;
    logic [SINGLE_LEN-1:0]   line_width;
    logic [ADDR_LEN-1:0]     addr_stride;
    logic                    axi_ug_idle;
    logic                    ddr_write_req;

    logic [DDR_ADDR_LEN-1:0] st_addr_out [2];
    logic [SINGLE_LEN-1:0]   ddr_len     [2];
    logic                    ddr_conf    [2];
    logic                    empty       [2];
    logic [BW-1:0]           wdata       [2];
    logic [ABUS-1:0]         bp_addr     [2];
    logic [DBUS-1:0]         bp_data     [2];
    logic                    idle        [2];
    logic [SINGLE_LEN-1:0]   beat_count  [2];

    logic [7:0] salt;
    int n_cmp = 0;
    int n_err = 0;

    bp_write_control_mg #(
        .X_MAC(X_MAC), .X_MESH(X_MESH), .ADDR_LEN(ADDR_LEN), .DATA_LEN(DATA_LEN),
        .DDR_ADDR_LEN(DDR_ADDR_LEN), .SINGLE_LEN(SINGLE_LEN), .READ_LAT(1),
        .FIFO_DEPTH(FIFO_DEPTH), .BUFFER_NUM(BN)
    ) u_l1 (
        .clk(clk), .rst(rst), .conf(conf), .ddr_st_addr(ddr_st_addr),
        .data_ddr_byte(data_ddr_byte), .bp_st_addr(bp_st_addr), .bp_st_mac(bp_st_mac),
        .line_num(line_num), .line_width(line_width), .addr_stride(addr_stride),
        .axi_ug_idle(axi_ug_idle), .ddr_st_addr_out(st_addr_out[0]), .ddr_len(ddr_len[0]),
        .ddr_conf(ddr_conf[0]), .ddr_write_empty(empty[0]), .ddr_write_req(ddr_write_req),
        .ddr_write_data_out(wdata[0]), .bp_addr_out(bp_addr[0]), .bp_data_in(bp_data[0]),
        .idle(idle[0]), .beat_count(beat_count[0])
    );

    bp_write_control_mg #(
        .X_MAC(X_MAC), .X_MESH(X_MESH), .ADDR_LEN(ADDR_LEN), .DATA_LEN(DATA_LEN),
        .DDR_ADDR_LEN(DDR_ADDR_LEN), .SINGLE_LEN(SINGLE_LEN), .READ_LAT(3),
        .FIFO_DEPTH(FIFO_DEPTH), .BUFFER_NUM(BN)
    ) u_l3 (
        .clk(clk), .rst(rst), .conf(conf), .ddr_st_addr(ddr_st_addr),
        .data_ddr_byte(data_ddr_byte), .bp_st_addr(bp_st_addr), .bp_st_mac(bp_st_mac),
        .line_num(line_num), .line_width(line_width), .addr_stride(addr_stride),
        .axi_ug_idle(axi_ug_idle), .ddr_st_addr_out(st_addr_out[1]), .ddr_len(ddr_len[1]),
        .ddr_conf(ddr_conf[1]), .ddr_write_empty(empty[1]), .ddr_write_req(ddr_write_req),
        .ddr_write_data_out(wdata[1]), .bp_addr_out(bp_addr[1]), .bp_data_in(bp_data[1]),
        .idle(idle[1]), .beat_count(beat_count[1])
    );

    // bank model: every bank returns {salt, bank id, address it was given}
    function automatic logic [DBUS-1:0] bank_bus(input logic [ABUS-1:0] a, input logic [7:0] s);
        logic [DBUS-1:0] r;
        for (int b = 0; b < BN; b++) r[b*DATA_LEN +: DATA_LEN] = {s, 8'(b), a[b*ADDR_LEN +: ADDR_LEN]};
        return r;
    endfunction

    logic [ABUS-1:0] hist1;
    logic [ABUS-1:0] hist3 [3];

    always @(posedge clk) begin
        hist1    <= bp_addr[0];
        hist3[0] <= bp_addr[1];
        hist3[1] <= hist3[0];
        hist3[2] <= hist3[1];
    end

    always_comb begin
        bp_data[0] = bank_bus(hist1, salt);
        bp_data[1] = bank_bus(hist3[2], salt);
    end

    // monitor: records popped beats and ddr_conf cycles just before each rising edge
    logic [BW-1:0] got0[$];
    logic [BW-1:0] got1[$];
    int conf_seen0 = 0;
    int conf_seen1 = 0;

    always begin
        @(negedge clk);
        #3;
        if (!rst) begin
            if (ddr_write_req && !empty[0]) got0.push_back(wdata[0]);
            if (ddr_write_req && !empty[1]) got1.push_back(wdata[1]);
            if (ddr_conf[0]) conf_seen0++;
            if (ddr_conf[1]) conf_seen1++;
        end
    end

    // job-level reference: beat for group at MAC index mac, word address a
    logic [BW-1:0] exp_q[$];

    function automatic logic [BW-1:0] model_beat(input int mac, input logic [15:0] a, input logic [7:0] s);
        logic [BW-1:0] r;
        for (int m = 0; m < X_MESH; m++) r[m*DATA_LEN +: DATA_LEN] = {s, 8'(mac + m * X_MAC), a};
        return r;
    endfunction

    task automatic build_expected(input int mac, input int lnum, input int lw, input int stride, input int st);
        exp_q.delete();
        for (int g = 0; g < lnum; g++)
            for (int c = 0; c < lw; c++)
                exp_q.push_back(model_beat((mac + g) % X_MAC, 16'(st + c * stride), salt));
    endtask

    // index of the first wrong beat, -2 for a wrong beat count, -1 when all match
    function automatic int first_bad(input logic [BW-1:0] q[$], input int base);
        if (q.size() != base + exp_q.size()) return -2;
        for (int k = 0; k < exp_q.size(); k++) if (q[base+k] !== exp_q[k]) return k;
        return -1;
    endfunction

    task automatic start_job(input int mac, input int lnum, input int lw, input int stride,
                             input int st, input logic [31:0] daddr, input logic [23:0] bytes);
        @(negedge clk);
        bp_st_mac     = MAC_W'(mac);
        line_num      = 24'(lnum);
        line_width    = 24'(lw);
        addr_stride   = 16'(stride);
        bp_st_addr    = 16'(st);
        ddr_st_addr   = daddr;
        data_ddr_byte = bytes;
        conf          = 1'b1;
        @(negedge clk);
        conf = 1'b0;
    endtask

    task automatic wait_done(input int n, input bit rand_req, input int b0, input int b1);
        int cyc = 0;
        while (!(got0.size() >= b0 + n && got1.size() >= b1 + n &&
                 idle[0] && idle[1] && empty[0] && empty[1]) && cyc <= 3000) begin
            @(negedge clk);
            if (rand_req) ddr_write_req = 1'($urandom_range(0, 1));
            cyc++;
        end
        ddr_write_req = 1'b1;
        if (cyc > 3000) begin
            n_cmp++; n_err++;
            $display("FAIL job_timeout: popped %0d/%0d beats, required %0d", got0.size() - b0, got1.size() - b1, n);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1; conf = 1'b0; ddr_st_addr = '0; data_ddr_byte = '0; bp_st_addr = '0;
        bp_st_mac = '0; line_num = '0; line_width = '0; addr_stride = '0;
        axi_ug_idle = 1'b1; ddr_write_req = 1'b0; salt = 8'h00;
        repeat (3) @(negedge clk);
        for (int i = 0; i < 2; i++) begin
            n_cmp++; if (empty[i] !== 1'b1) begin n_err++; $display("FAIL reset_empty[%0d]: got %b want 1", i, empty[i]); end
            n_cmp++; if (ddr_conf[i] !== 1'b0) begin n_err++; $display("FAIL reset_ddr_conf[%0d]: got %b want 0", i, ddr_conf[i]); end
            n_cmp++; if (ddr_len[i] !== '0) begin n_err++; $display("FAIL reset_ddr_len[%0d]: got %0h want 0", i, ddr_len[i]); end
            n_cmp++; if (st_addr_out[i] !== '0) begin n_err++; $display("FAIL reset_st_addr[%0d]: got %0h want 0", i, st_addr_out[i]); end
            n_cmp++; if (bp_addr[i] !== '0) begin n_err++; $display("FAIL reset_bp_addr[%0d]: got nonzero want 0", i); end
            n_cmp++; if (beat_count[i] !== '0) begin n_err++; $display("FAIL reset_beat_count[%0d]: got %0d want 0", i, beat_count[i]); end
            n_cmp++; if (idle[i] !== 1'b1) begin n_err++; $display("FAIL reset_idle[%0d]: got %b want 1", i, idle[i]); end
        end
        rst = 1'b0;
    endtask

    // common job body: run, wait, then compare streams, pulse count and beat_count
    task automatic run_job(input string name, input int mac, input int lnum, input int lw,
                           input int stride, input int st, input bit rand_req);
        int b0, b1, c0, c1, r0, r1, n;
        logic [31:0] daddr;
        logic [23:0] bytes;
        daddr = $urandom; bytes = 24'($urandom);
        salt = 8'($urandom);
        b0 = got0.size(); b1 = got1.size(); c0 = conf_seen0; c1 = conf_seen1;
        n = lnum * lw;
        build_expected(mac, lnum, lw, stride, st);
        ddr_write_req = 1'b1;
        start_job(mac, lnum, lw, stride, st, daddr, bytes);
        for (int i = 0; i < 2; i++) begin
            n_cmp++; if (ddr_conf[i] !== 1'b1) begin n_err++; $display("FAIL %s_ddr_conf[%0d]: got %b want 1", name, i, ddr_conf[i]); end
            n_cmp++; if (st_addr_out[i] !== daddr) begin n_err++; $display("FAIL %s_st_addr[%0d]: got %0h want %0h", name, i, st_addr_out[i], daddr); end
            n_cmp++; if (ddr_len[i] !== bytes) begin n_err++; $display("FAIL %s_ddr_len[%0d]: got %0h want %0h", name, i, ddr_len[i], bytes); end
        end
        wait_done(n, rand_req, b0, b1);
        r0 = first_bad(got0, b0);
        r1 = first_bad(got1, b1);
        n_cmp++; if (r0 != -1) begin n_err++; $display("FAIL %s_stream_lat1: first bad %0d (got %0d beats) want %0d matching beats", name, r0, got0.size() - b0, n); end
        n_cmp++; if (r1 != -1) begin n_err++; $display("FAIL %s_stream_lat3: first bad %0d (got %0d beats) want %0d matching beats", name, r1, got1.size() - b1, n); end
        n_cmp++; if (conf_seen0 - c0 != 1 || conf_seen1 - c1 != 1) begin n_err++; $display("FAIL %s_conf_pulse: got %0d/%0d cycles want 1", name, conf_seen0 - c0, conf_seen1 - c1); end
        n_cmp++; if (beat_count[0] !== 24'(n) || beat_count[1] !== 24'(n)) begin n_err++; $display("FAIL %s_beat_count: got %0d/%0d want %0d", name, beat_count[0], beat_count[1], n); end
    endtask

    task automatic test_basic();
        run_job("basic", 0, 2, 4, 1, 16'h0010, 1'b0);
        n_cmp++; if (idle[0] !== 1'b1 || idle[1] !== 1'b1) begin n_err++; $display("FAIL basic_idle_after: got %b/%b want 1", idle[0], idle[1]); end
        axi_ug_idle = 1'b0;
        #1;
        n_cmp++; if (idle[0] !== 1'b0 || idle[1] !== 1'b0) begin n_err++; $display("FAIL basic_idle_engine_busy: got %b/%b want 0", idle[0], idle[1]); end
        axi_ug_idle = 1'b1;
    endtask

    task automatic test_wrap();
        run_job("wrap", 3, 3, 2, 4, 16'hFFFC, 1'b0);
    endtask

    task automatic test_random();
        for (int j = 0; j < 6; j++) begin
            run_job("random", $urandom_range(0, X_MAC - 1), $urandom_range(1, 5), $urandom_range(1, 6),
                    $urandom_range(0, 16'hFFFF), $urandom_range(0, 16'hFFFF), 1'b1);
        end
    endtask

    task automatic test_backpressure();
        int b0, b1, r0, r1, mac, stride, st;
        logic [15:0] stall_addr;
        mac = $urandom_range(0, X_MAC - 1); stride = $urandom_range(1, 255); st = $urandom_range(0, 16'hFFFF);
        salt = 8'($urandom);
        build_expected(mac, 1, 40, stride, st);
        stall_addr = 16'(st + 16 * stride);
        b0 = got0.size(); b1 = got1.size();
        ddr_write_req = 1'b0;
        start_job(mac, 1, 40, stride, st, 32'h1000, 24'd40);
        repeat (60) @(negedge clk);
        for (int i = 0; i < 2; i++) begin
            n_cmp++; if (beat_count[i] !== 24'd16) begin n_err++; $display("FAIL bp_fill[%0d]: got %0d beats want 16", i, beat_count[i]); end
            n_cmp++; if (empty[i] !== 1'b0) begin n_err++; $display("FAIL bp_empty[%0d]: got %b want 0", i, empty[i]); end
            n_cmp++; if (bp_addr[i][15:0] !== stall_addr) begin n_err++; $display("FAIL bp_stall_addr[%0d]: got %0h want %0h", i, bp_addr[i][15:0], stall_addr); end
        end
        ddr_write_req = 1'b1;
        wait_done(40, 1'b0, b0, b1);
        r0 = first_bad(got0, b0);
        r1 = first_bad(got1, b1);
        n_cmp++; if (r0 != -1) begin n_err++; $display("FAIL bp_stream_lat1: first bad %0d want 40 matching beats", r0); end
        n_cmp++; if (r1 != -1) begin n_err++; $display("FAIL bp_stream_lat3: first bad %0d want 40 matching beats", r1); end
    endtask

    task automatic test_zero_and_ignore();
        int b0, b1, c0, c1, r0;
        logic [31:0] daddr;
        ddr_write_req = 1'b1;
        c0 = conf_seen0;
        start_job(1, 3, 0, 1, 16'h0040, 32'h2000, 24'd0);
        n_cmp++; if (ddr_conf[0] !== 1'b1 || ddr_conf[1] !== 1'b1) begin n_err++; $display("FAIL zero_conf: got %b/%b want 1", ddr_conf[0], ddr_conf[1]); end
        @(negedge clk);
        for (int i = 0; i < 2; i++) begin
            n_cmp++; if (idle[i] !== 1'b1) begin n_err++; $display("FAIL zero_idle[%0d]: got %b want 1", i, idle[i]); end
            n_cmp++; if (empty[i] !== 1'b1 || beat_count[i] !== '0) begin n_err++; $display("FAIL zero_beats[%0d]: empty %b count %0d want 1/0", i, empty[i], beat_count[i]); end
        end
        n_cmp++; if (conf_seen0 - c0 != 1) begin n_err++; $display("FAIL zero_conf_pulse: got %0d cycles want 1", conf_seen0 - c0); end

        salt = 8'($urandom);
        daddr = $urandom;
        build_expected(2, 1, 8, 3, 16'h0100);
        b0 = got0.size(); b1 = got1.size(); c1 = conf_seen1;
        start_job(2, 1, 8, 3, 16'h0100, daddr, 24'd32);
        bp_st_mac = 2'd0; line_num = 24'd4; line_width = 24'd8; addr_stride = 16'd1;
        bp_st_addr = 16'h0999; ddr_st_addr = ~daddr; conf = 1'b1;
        @(negedge clk);
        conf = 1'b0;
        n_cmp++; if (ddr_conf[0] !== 1'b0 || ddr_conf[1] !== 1'b0) begin n_err++; $display("FAIL ignore_conf: got %b/%b want 0", ddr_conf[0], ddr_conf[1]); end
        n_cmp++; if (st_addr_out[0] !== daddr || st_addr_out[1] !== daddr) begin n_err++; $display("FAIL ignore_st_addr: got %0h want %0h", st_addr_out[0], daddr); end
        wait_done(8, 1'b0, b0, b1);
        r0 = first_bad(got0, b0);
        n_cmp++; if (r0 != -1 || first_bad(got1, b1) != -1) begin n_err++; $display("FAIL ignore_stream: first bad %0d want 8 matching beats", r0); end
        n_cmp++; if (beat_count[0] !== 24'd8 || beat_count[1] !== 24'd8) begin n_err++; $display("FAIL ignore_beat_count: got %0d/%0d want 8", beat_count[0], beat_count[1]); end
        n_cmp++; if (conf_seen1 - c1 != 1) begin n_err++; $display("FAIL ignore_conf_pulse: got %0d cycles want 1", conf_seen1 - c1); end
    endtask

    task automatic test_reset_mid_job();
        int cyc = 0;
        ddr_write_req = 1'b1;
        salt = 8'($urandom);
        start_job(1, 4, 4, 2, 16'h0200, 32'h3000, 24'd64);
        while (beat_count[0] < 24'd5 && cyc < 200) begin
            @(negedge clk);
            cyc++;
        end
        n_cmp++; if (beat_count[0] !== 24'd5) begin n_err++; $display("FAIL midrst_progress: got %0d beats want 5", beat_count[0]); end
        #1 rst = 1'b1;
        #1;
        for (int i = 0; i < 2; i++) begin
            n_cmp++; if (empty[i] !== 1'b1) begin n_err++; $display("FAIL midrst_empty[%0d]: got %b want 1", i, empty[i]); end
            n_cmp++; if (ddr_conf[i] !== 1'b0) begin n_err++; $display("FAIL midrst_conf[%0d]: got %b want 0", i, ddr_conf[i]); end
            n_cmp++; if (bp_addr[i] !== '0) begin n_err++; $display("FAIL midrst_bp_addr[%0d]: got nonzero want 0", i); end
            n_cmp++; if (beat_count[i] !== '0) begin n_err++; $display("FAIL midrst_beat_count[%0d]: got %0d want 0", i, beat_count[i]); end
        end
        @(negedge clk);
        rst = 1'b0;
        run_job("after_reset", $urandom_range(0, X_MAC - 1), 4, 4, $urandom_range(0, 16'hFFFF), $urandom_range(0, 16'hFFFF), 1'b1);
    endtask

    initial begin
        test_reset();
        test_basic();
        test_wrap();
        test_backpressure();
        test_zero_and_ignore();
        test_random();
        test_reset_mid_job();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
